// File: rtl/audio_pkg.sv
// Shared audio definitions for the SDM ADC decimation chain and its I2S output stage.
package audio_pkg;

    localparam int SAMPLE_W        = 16;
    localparam int SLOTS_PER_FRAME = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO holding audio samples.
module sample_fifo import audio_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  sample_t                  din,
    output sample_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    sample_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: buffers mono samples and sends each one on both stereo channels.
module audio_i2s_tx import audio_pkg::*; #(
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [15:0]                   data_in,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic                          overflow
);

    localparam int DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int SLOT_W = $clog2(SLOTS_PER_FRAME);

    logic [DIV_W-1:0]   div_cnt;
    logic [SLOT_W-1:0]  slot;
    logic [SLOT_W-1:0]  slot_nxt;
    logic [31:0]        shift_reg;
    logic               div_tc;
    logic               fall_tick;
    logic               slot1_entry;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    sample_t            fifo_din;
    sample_t            fifo_dout;

    assign fifo_din    = sample_t'(data_in);
    assign div_tc      = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign fall_tick   = div_tc && bclk;
    assign slot_nxt    = slot + 1'b1;
    assign slot1_entry = fall_tick && (slot_nxt == SLOT_W'(1));
    assign pop         = slot1_entry && !fifo_empty;
    assign sdata       = shift_reg[31];

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (valid_in),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Slot counter starts at 31 so the first falling edge lands on slot 0 of a fresh frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot      <= '1;
            lrclk     <= 1'b0;
            shift_reg <= '0;
        end else if (fall_tick) begin
            slot  <= slot_nxt;
            lrclk <= slot_nxt[SLOT_W-1];
            if (slot_nxt == SLOT_W'(1))
                shift_reg <= pop ? {fifo_dout, fifo_dout} : 32'd0;
            else
                shift_reg <= shift_reg << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            underflow <= slot1_entry && fifo_empty;
            overflow  <= valid_in && fifo_full && !pop;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx at BCLK_DIV=2, FIFO_DEPTH=8 (one frame = 128 clk cycles).
module tb_audio_i2s_tx;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [15:0] data_in;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [3:0]  fifo_level;
    logic        underflow;
    logic        overflow;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    int ufCount    = 0;
    int ofCount    = 0;

    logic [15:0] word;
    logic [15:0] pattern;

    audio_i2s_tx #(
        .BCLK_DIV   (2),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .fifo_level (fifo_level),
        .underflow  (underflow),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, actual, expected);
        end
    endtask

    // One clk edge; outputs are then sampled at the following negedge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (underflow === 1'b1) ufCount++;
        if (overflow === 1'b1)  ofCount++;
    endtask

    task automatic tickTo(input int n);
        while (cyc < n) tick();
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d);
        valid_in = v;
        data_in  = d;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic applyReset(input int n);
        reset    = 1'b1;
        valid_in = 1'b0;
        repeat (n) tick();
        reset   = 1'b0;
        cyc     = 0;
        ufCount = 0;
        ofCount = 0;
    endtask

    // Slot s of the frame whose slot 1 is entered at edge base is entered at base + 4*(s-1).
    task automatic collectWord(input int base, output logic [15:0] w);
        w = '0;
        for (int s = 1; s <= 16; s++) begin
            tickTo(base + 4 * (s - 1));
            w[16-s] = sdata;
        end
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;

        $display("[TB] reset values and first bclk edges");
        applyReset(5);
        checkOutput("rst_bclk",  32'(bclk), 32'd0);
        checkOutput("rst_lrclk", 32'(lrclk), 32'd0);
        checkOutput("rst_sdata", 32'(sdata), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_uf",    32'(underflow), 32'd0);
        checkOutput("rst_of",    32'(overflow), 32'd0);
        tickTo(1); checkOutput("bclk_c1", 32'(bclk), 32'd0);
        tickTo(2); checkOutput("bclk_rise_c2", 32'(bclk), 32'd1);
        tickTo(3); checkOutput("bclk_c3", 32'(bclk), 32'd1);
        tickTo(4);
        checkOutput("bclk_fall_c4", 32'(bclk), 32'd0);
        checkOutput("slot0_lrclk", 32'(lrclk), 32'd0);
        checkOutput("slot0_sdata", 32'(sdata), 32'd0);

        $display("[TB] single sample A5C3 on both channels");
        applyReset(5);
        pattern = 16'hA5C3;
        applyStimulus(1'b1, pattern);
        tickTo(2);
        checkOutput("single_level_push", 32'(fifo_level), 32'd1);
        for (int s = 1; s <= 32; s++) begin
            int slotNum;
            int bitIdx;
            slotNum = s % 32;
            bitIdx  = (s <= 16) ? 16 - s : 32 - s;
            tickTo(4 + 4 * s);
            checkOutput($sformatf("single_sdata_slot%0d", slotNum), 32'(sdata), 32'(pattern[bitIdx]));
            checkOutput($sformatf("single_lrclk_slot%0d", slotNum), 32'(lrclk), (slotNum >= 16) ? 32'd1 : 32'd0);
            if (s == 1) checkOutput("single_level_pop", 32'(fifo_level), 32'd0);
        end
        checkOutput("single_no_underflow", 32'(ufCount), 32'd0);

        $display("[TB] underflow with no pushes");
        applyReset(5);
        begin
            int firstUf;
            int lastUf;
            logic anyData;
            firstUf = -1;
            lastUf  = -1;
            anyData = 1'b0;
            while (cyc < 300) begin
                tick();
                if (underflow === 1'b1) begin
                    if (firstUf < 0) firstUf = cyc;
                    lastUf = cyc;
                end
                if (sdata !== 1'b0) anyData = 1'b1;
            end
            checkOutput("uf_count", 32'(ufCount), 32'd3);
            checkOutput("uf_first_cycle", 32'(firstUf), 32'd8);
            checkOutput("uf_last_cycle", 32'(lastUf), 32'd264);
            checkOutput("uf_sdata_quiet", 32'(anyData), 32'd0);
        end

        $display("[TB] overflow with ten back-to-back pushes");
        applyReset(5);
        tickTo(8);
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 16'(16'h1111 * i));
        tickTo(20);
        checkOutput("ovf_level_full", 32'(fifo_level), 32'd8);
        checkOutput("ovf_pulses", 32'(ofCount), 32'd2);
        for (int f = 1; f <= 9; f++) begin
            collectWord(8 + 128 * f, word);
            checkOutput($sformatf("ovf_word%0d", f), 32'(word), (f <= 8) ? 32'(16'h1111 * f) : 32'd0);
        end
        tickTo(1162);
        checkOutput("ovf_uf_after_drain", 32'(ufCount), 32'd2);

        $display("[TB] push while full coinciding with a pop");
        applyReset(5);
        tickTo(8);
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(16'h0101 * i));
        tickTo(20);
        checkOutput("fullpp_level_before", 32'(fifo_level), 32'd8);
        tickTo(135);
        applyStimulus(1'b1, 16'hBEEF);
        checkOutput("fullpp_level_at_pop", 32'(fifo_level), 32'd8);
        collectWord(136, word);
        checkOutput("fullpp_word", 32'(word), 32'h0101);
        checkOutput("fullpp_level_after", 32'(fifo_level), 32'd8);
        checkOutput("fullpp_no_overflow", 32'(ofCount), 32'd0);

        $display("[TB] reset during slot 20 with three samples queued");
        applyReset(5);
        tickTo(8);
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 16'(16'h7000 + i));
        tickTo(85);
        checkOutput("mid_level_before", 32'(fifo_level), 32'd3);
        checkOutput("mid_lrclk_before", 32'(lrclk), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("mid_level", 32'(fifo_level), 32'd0);
        checkOutput("mid_bclk", 32'(bclk), 32'd0);
        checkOutput("mid_lrclk", 32'(lrclk), 32'd0);
        checkOutput("mid_sdata", 32'(sdata), 32'd0);
        reset   = 1'b0;
        cyc     = 0;
        ufCount = 0;
        ofCount = 0;
        tickTo(2);
        checkOutput("mid_restart_bclk", 32'(bclk), 32'd1);
        collectWord(8, word);
        checkOutput("mid_frame0_word", 32'(word), 32'd0);
        collectWord(136, word);
        checkOutput("mid_frame1_word", 32'(word), 32'd0);
        checkOutput("mid_uf_count", 32'(ufCount), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
